// File: rtl/and_gate.sv
// and_gate: bitwise AND (y) with registered result (y_reg/out_valid), reduction flags, popcount and saturating all-ones counter (match_cnt, cleared by cnt_clr)
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  output logic [WIDTH-1:0]             y,
  input  logic                         in_valid,
  input  logic                         cnt_clr,
  output logic [WIDTH-1:0]             y_reg,
  output logic                         out_valid,
  output logic                         all_set,
  output logic                         any_set,
  output logic [$clog2(WIDTH+1)-1:0]   ones_cnt,
  output logic [CNT_W-1:0]             match_cnt
);
  localparam int OW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] y_q, y_d;
  logic             v_q, v_d;
  logic [CNT_W-1:0] m_q, m_d;
  logic [OW-1:0]    pop;
  assign y = a & b;
  always_comb begin
    y_d = in_valid ? y : y_q;
    v_d = in_valid;
    m_d = cnt_clr ? '0 : (in_valid && (&y) && !(&m_q)) ? m_q + CNT_W'(1) : m_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
      v_q <= 1'b0;
      m_q <= '0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
      m_q <= m_d;
    end
  end
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + OW'(y_q[i]);
  end
  assign y_reg     = y_q;
  assign out_valid = v_q;
  assign all_set   = &y_q;
  assign any_set   = |y_q;
  assign ones_cnt  = pop;
  assign match_cnt = m_q;
endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed scoreboard bench for and_gate at WIDTH=1, WIDTH=8 and WIDTH=8/CNT_W=2
module tb_and_gate;
  logic clk, rst, run;
  logic a1, b1, iv1, y1, yr1, ov1, all1, any1, ones1;
  logic [15:0] m1;
  logic [7:0] a8, b8, y8, yr8, y82, yr82;
  logic iv8, clr8, ov8, all8, any8, ov82, all82, any82;
  logic [3:0] ones8, ones82;
  logic [15:0] m8;
  logic [1:0] m2;
  int checks, errors;
  typedef struct {
    logic [7:0]  y;
    logic        all;
    logic        any;
    logic [3:0]  ones;
    logic [15:0] m8;
    logic [1:0]  m2;
  } exp_t;
  exp_t q[$];

  and_gate #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .in_valid(iv1), .cnt_clr(1'b0),
    .y_reg(yr1), .out_valid(ov1), .all_set(all1), .any_set(any1), .ones_cnt(ones1), .match_cnt(m1)
  );
  and_gate #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .y(y8), .in_valid(iv8), .cnt_clr(clr8),
    .y_reg(yr8), .out_valid(ov8), .all_set(all8), .any_set(any8), .ones_cnt(ones8), .match_cnt(m8)
  );
  and_gate #(.WIDTH(8), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .y(y82), .in_valid(iv8), .cnt_clr(clr8),
    .y_reg(yr82), .out_valid(ov82), .all_set(all82), .any_set(any82), .ones_cnt(ones82), .match_cnt(m2)
  );

  initial begin
    clk = 0;
    wait (run);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [7:0] ey, input logic eall, input logic eany,
                       input logic [3:0] eones, input logic [15:0] em8, input logic [1:0] em2);
    exp_t e;
    a8 = a; b8 = b; iv8 = 1; clr8 = c;
    #1;
    chk("y_comb", y8, ey);
    e.y = ey; e.all = eall; e.any = eany; e.ones = eones; e.m8 = em8; e.m2 = em2;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ov8) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("y_reg", yr8, e.y);
        chk("all_set", all8, e.all);
        chk("any_set", any8, e.any);
        chk("ones_cnt", ones8, e.ones);
        chk("match_cnt", m8, e.m8);
        chk("w2_out_valid", ov82, 1);
        chk("w2_y_reg", yr82, e.y);
        chk("w2_match_cnt", m2, e.m2);
      end
    end
  end

  initial begin
    logic [1:0] tv [4];
    logic       ty [4];
    checks = 0; errors = 0; run = 0;
    rst = 1; iv1 = 0; a8 = 0; b8 = 0; iv8 = 0; clr8 = 0;
    tv[0] = 2'b00; tv[1] = 2'b01; tv[2] = 2'b10; tv[3] = 2'b11;
    ty[0] = 0; ty[1] = 0; ty[2] = 0; ty[3] = 1;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = tv[i];
      #19;
      chk("tt_y", y1, ty[i]);
      #1;
    end
    a1 = 1; b1 = 1; iv1 = 1; a8 = 8'hFF; b8 = 8'hFF; iv8 = 1;
    run = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_y_reg", yr8, 0);
      chk("rst_out_valid", ov8, 0);
      chk("rst_match", m8, 0);
      chk("rst_y", y8, 8'hFF);
      chk("rst_y1", y1, 1);
      chk("rst_y_reg1", yr1, 0);
      chk("rst_all_set1", all1, 0);
      chk("rst_any_set8", any8, 0);
      chk("rst_ones8", ones8, 0);
    end
    iv1 = 0; iv8 = 0; rst = 0;
    cyc();
    issue(8'hF0, 8'h3C, 0, 8'h30, 0, 1, 2, 0, 0);
    iv8 = 0;
    cyc();
    chk("idle_out_valid", ov8, 0);
    chk("idle_y_reg_hold", yr8, 8'h30);
    issue(8'hFF, 8'hFF, 0, 8'hFF, 1, 1, 8, 1, 1);
    issue(8'hFF, 8'hFF, 0, 8'hFF, 1, 1, 8, 2, 2);
    issue(8'hFF, 8'hFF, 0, 8'hFF, 1, 1, 8, 3, 3);
    issue(8'hFF, 8'hFE, 0, 8'hFE, 0, 1, 7, 3, 3);
    issue(8'hFF, 8'hFF, 0, 8'hFF, 1, 1, 8, 4, 3);
    issue(8'hFF, 8'hFF, 0, 8'hFF, 1, 1, 8, 5, 3);
    issue(8'hFF, 8'hFF, 1, 8'hFF, 1, 1, 8, 0, 0);
    issue(8'hFF, 8'hFF, 0, 8'hFF, 1, 1, 8, 1, 1);
    issue(8'hFF, 8'hFF, 0, 8'hFF, 1, 1, 8, 2, 2);
    issue(8'hFF, 8'hFF, 0, 8'hFF, 1, 1, 8, 3, 3);
    issue(8'hFF, 8'hFF, 0, 8'hFF, 1, 1, 8, 4, 3);
    issue(8'hFF, 8'hFF, 0, 8'hFF, 1, 1, 8, 5, 3);
    iv8 = 0; clr8 = 0;
    cyc();
    cyc();
    chk("end_out_valid", ov8, 0);
    chk("end_match_hold", m8, 5);
    chk("end_w2_match_hold", m2, 3);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
- Parameterised bitwise AND unit with a registered result path and result statistics.
- Provides a zero-latency combinational AND output, a one-cycle registered AND output with valid, reduction flags, a population count, and a saturating "all-ones" event counter.
- Used as a leaf logic primitive and as a small self-checking datapath element.
- The WIDTH=1 default behaves as a plain 2-input AND gate.

Parameters:
- WIDTH, 1, operand and result width in bits (1..64).
- CNT_W, 16, width of the all-ones event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  WIDTH  combinational result, a & b.
- in_valid  input  1  sample a/b into the registered path this cycle.
- cnt_clr  input  1  synchronous clear of the event counter.
- y_reg  output  WIDTH  registered result.
- out_valid  output  1  y_reg updated on the previous edge.
- all_set  output  1  &y_reg.
- any_set  output  1  |y_reg.
- ones_cnt  output  $clog2(WIDTH+1) (min 1)  number of 1 bits in y_reg.
- match_cnt  output  CNT_W  count of accepted samples whose result was all ones.

Behaviour:
- y = a & b, purely combinational, bitwise:
  - no clock or reset dependency;
  - updates within the same delta as a/b changes;
  - X/Z on an input bit follows standard Verilog & semantics for that bit.
- Reset (rst=1 at a rising clk edge) forces the following, with priority over in_valid and cnt_clr:
  - y_reg=0, out_valid=0, match_cnt=0;
  - hence all_set=0, any_set=0, ones_cnt=0 (for WIDTH=1, all_set mirrors y_reg, so also 0).
- Registered path, on a rising edge with rst=0 and in_valid=1:
  - y_reg <= a & b;
  - out_valid <= 1.
- With in_valid=0: y_reg holds and out_valid <= 0. out_valid is a single-cycle pulse per accepted sample.
- Latency: a/b to y is 0 cycles; a/b to y_reg/out_valid is 1 cycle. Back-to-back in_valid gives one result per cycle with no stalls.
- all_set, any_set and ones_cnt are combinational functions of y_reg only. They are valid whenever y_reg is, regardless of out_valid.
- ones_cnt range is 0..WIDTH.
- match_cnt, evaluated at each edge with rst=0:
  - cnt_clr=1: match_cnt <= 0. This takes priority over an increment in the same cycle; the coincident sample is not counted.
  - Else, if in_valid=1 and (a & b) is all ones: match_cnt increments by 1.
  - It saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-stream discards the pending sample. The first accepted sample after rst deasserts produces out_valid on the following edge.
- No internal state beyond y_reg, out_valid and match_cnt.

Test Plan:
- WIDTH=1 truth table, no clock activity: a,b = 00, 01, 10, 11, each held 20 ns -> y = 0, 0, 0, 1, with y settled before each 20 ns step ends.
- Reset: rst=1 for 2 cycles with a=b=1 and in_valid=1 -> y_reg=0, out_valid=0, match_cnt=0, while y=1 throughout.
- WIDTH=8, in_valid=1 for one cycle with a=8'hF0, b=8'h3C -> y=8'h30 immediately. Next cycle: y_reg=8'h30, out_valid=1, ones_cnt=2, any_set=1, all_set=0. The cycle after: out_valid=0 and y_reg holds 8'h30.
- WIDTH=8, three back-to-back samples a=b=8'hFF, then one sample a=8'hFF, b=8'hFE -> match_cnt=3, and the last result gives y_reg=8'hFE, all_set=0, ones_cnt=7.
- cnt_clr asserted in the same cycle as an all-ones sample with match_cnt=5 -> match_cnt=0 next cycle, while y_reg still updates and out_valid=1.
- CNT_W=2: five consecutive all-ones samples -> match_cnt reads 1, 2, 3, 3, 3 (saturates, no wrap).
